// File: rtl/srt_div_arb.sv
// Round-robin arbiter/sequencer sharing one radix-4 SRT divider among NUM_REQ requesters.
// Operands are held for DIV_LAT cycles, then quotient/remainder are captured and returned with the ID.
module srt_div_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIV_LAT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_op1_i,
    input  logic [8*NUM_REQ-1:0] req_op2_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [ID_W-1:0]      resp_id_o,
    output logic [7:0]           resp_quo_o,
    output logic [7:0]           resp_rem_o,
    output logic                 resp_dz_o,
    output logic [7:0]           div_op1_o,
    output logic [7:0]           div_op2_o,
    output logic                 div_start_o,
    input  logic [7:0]           div_quo_i,
    input  logic [7:0]           div_rem_i
);

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr_next;
    logic [7:0]         op1_sel;
    logic [7:0]         op2_sel;

    // Rotating-priority search starting at ptr.
    // NOTE: every variable gets a default before the loop, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        op1_sel   = '0;
        op2_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && req_valid_i[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                op1_sel    = req_op1_i[8*idx +: 8];
                op2_sel    = req_op2_i[8*idx +: 8];
            end
        end
    end

    assign ptr_next    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign req_ready_o = (state == IDLE && !rst) ? grant : '0;

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            resp_valid_o <= 1'b0;
            resp_id_o    <= '0;
            resp_quo_o   <= '0;
            resp_rem_o   <= '0;
            resp_dz_o    <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            div_start_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        div_op1_o <= op1_sel;
                        div_op2_o <= op2_sel;
                        resp_id_o <= grant_idx;
                        ptr       <= ptr_next;
                        if (op2_sel == 8'd0) begin
                            // Divide-by-zero is answered locally; the divider never sees it.
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_quo_o   <= 8'hFF;
                            resp_rem_o   <= op1_sel;
                            resp_dz_o    <= 1'b1;
                        end else begin
                            state       <= BUSY;
                            cnt         <= CNT_W'(DIV_LAT - 1);
                            div_start_o <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    div_start_o <= 1'b0;
                    if (cnt == '0) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_quo_o   <= div_quo_i;
                        resp_rem_o   <= div_rem_i;
                        resp_dz_o    <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
